tl_ram_terminal: RTL and testbench

Terminal TileLink device that sits directly downstream of the link adapter's device-side port and serves TL-UL/TL-UH traffic from a single-port synchronous SRAM. It converts multi-beat Get/Put bursts into one SRAM access per beat and returns Access/AccessAckData responses on D. Channels B, C and E are tied off, so the block never issues probes.

---
 rtl/tl_ram_terminal.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_tl_ram_terminal.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_ram_terminal.sv
// Terminal TileLink UL/UH device serving Get/Put bursts from a single-port synchronous SRAM.
// Optional macro TL_RAM_TERMINAL_BOUNDS_EN: deny requests with address bits above the RAM range.
module tl_ram_terminal #(
    parameter int unsigned DataWidth     = 64,
    parameter int unsigned AddrWidth     = 56,
    parameter int unsigned SourceWidth   = 2,
    parameter int unsigned SinkWidth     = 1,
    parameter int unsigned MaxSize       = 6,
    parameter int unsigned RamDepth      = 1024,
    parameter int unsigned SizeWidth     = 3,
    localparam int unsigned MaskWidth    = DataWidth / 8,
    localparam int unsigned RamAddrWidth = $clog2(RamDepth)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    // A channel
    input  logic                    host_a_valid,
    output logic                    host_a_ready,
    input  logic [2:0]              host_a_opcode,
    input  logic [2:0]              host_a_param,
    input  logic [SizeWidth-1:0]    host_a_size,
    input  logic [SourceWidth-1:0]  host_a_source,
    input  logic [AddrWidth-1:0]    host_a_address,
    input  logic [MaskWidth-1:0]    host_a_mask,
    input  logic [DataWidth-1:0]    host_a_data,
    input  logic                    host_a_corrupt,
    // B channel
    output logic                    host_b_valid,
    input  logic                    host_b_ready,
    output logic [2:0]              host_b_opcode,
    output logic [1:0]              host_b_param,
    output logic [SizeWidth-1:0]    host_b_size,
    output logic [SourceWidth-1:0]  host_b_source,
    output logic [AddrWidth-1:0]    host_b_address,
    output logic [MaskWidth-1:0]    host_b_mask,
    output logic [DataWidth-1:0]    host_b_data,
    output logic                    host_b_corrupt,
    // C channel
    input  logic                    host_c_valid,
    output logic                    host_c_ready,
    input  logic [2:0]              host_c_opcode,
    input  logic [2:0]              host_c_param,
    input  logic [SizeWidth-1:0]    host_c_size,
    input  logic [SourceWidth-1:0]  host_c_source,
    input  logic [AddrWidth-1:0]    host_c_address,
    input  logic [DataWidth-1:0]    host_c_data,
    input  logic                    host_c_corrupt,
    // D channel
    output logic                    host_d_valid,
    input  logic                    host_d_ready,
    output logic [2:0]              host_d_opcode,
    output logic [1:0]              host_d_param,
    output logic [SizeWidth-1:0]    host_d_size,
    output logic [SourceWidth-1:0]  host_d_source,
    output logic [SinkWidth-1:0]    host_d_sink,
    output logic                    host_d_denied,
    output logic [DataWidth-1:0]    host_d_data,
    output logic                    host_d_corrupt,
    // E channel
    input  logic                    host_e_valid,
    output logic                    host_e_ready,
    input  logic [SinkWidth-1:0]    host_e_sink,
    // SRAM
    output logic                    ram_req_o,
    output logic                    ram_we_o,
    output logic [RamAddrWidth-1:0] ram_addr_o,
    output logic [MaskWidth-1:0]    ram_wmask_o,
    output logic [DataWidth-1:0]    ram_wdata_o,
    input  logic [DataWidth-1:0]    ram_rdata_i
);

    localparam int unsigned Offset   = $clog2(MaskWidth);
    localparam int unsigned BeatCntW = (MaxSize > Offset) ? MaxSize - Offset : 1;

    localparam logic [2:0] OpPutFull    = 3'd0;
    localparam logic [2:0] OpPutPartial = 3'd1;
    localparam logic [2:0] OpGet        = 3'd4;
    localparam logic [2:0] OpIntent     = 3'd5;

    localparam logic [2:0] DAccessAck     = 3'd0;
    localparam logic [2:0] DAccessAckData = 3'd1;
    localparam logic [2:0] DHintAck       = 3'd2;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWrite,
        StWack,
        StAtom,
        StAresp
    } state_e;

    state_e                  state_q, state_d;
    logic [BeatCntW-1:0]     cnt_q, cnt_d;
    logic [BeatCntW-1:0]     idx_q, idx_d;
    logic                    a_ready_q, a_ready_d;
    logic                    d_valid_q, d_valid_d;
    logic                    fresh_q;
    logic [DataWidth-1:0]    hold_q;
    logic [2:0]              op_q;
    logic [SizeWidth-1:0]    size_q;
    logic [SourceWidth-1:0]  source_q;
    logic [RamAddrWidth-1:0] base_q;
    logic [BeatCntW-1:0]     beats_q;
    logic                    oob_q;

    logic                    a_fire, d_fire, oob_a, accept;
    logic [BeatCntW-1:0]     a_beats_m1;
    logic [RamAddrWidth-1:0] a_index;

    // Beats in a transfer minus one: one beat unless the transfer exceeds the bus width.
    function automatic logic [BeatCntW-1:0] beats_m1(input logic [SizeWidth-1:0] size);
        if (32'(size) > Offset) begin
            return BeatCntW'((32'd1 << (32'(size) - Offset)) - 32'd1);
        end
        return '0;
    endfunction

`ifdef TL_RAM_TERMINAL_BOUNDS_EN
    assign oob_a = (host_a_address >> (Offset + RamAddrWidth)) != '0;
`else
    assign oob_a = 1'b0;
`endif

    assign a_fire     = host_a_valid && host_a_ready;
    assign d_fire     = host_d_valid && host_d_ready;
    assign accept     = a_fire && (state_q == StIdle);
    assign a_beats_m1 = beats_m1(host_a_size);
    assign a_index    = host_a_address[Offset +: RamAddrWidth];

    // State, beat counters and handshake flags.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            idx_q     <= '0;
            a_ready_q <= 1'b1;
            d_valid_q <= 1'b0;
            fresh_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            a_ready_q <= a_ready_d;
            d_valid_q <= d_valid_d;
            if (ram_req_o && !ram_we_o) begin
                fresh_q <= 1'b1;
            end else if (host_d_valid && !host_d_ready) begin
                fresh_q <= 1'b0;
            end
        end
    end

    // Request context and stalled read data.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            op_q     <= host_a_opcode;
            size_q   <= host_a_size;
            source_q <= host_a_source;
            base_q   <= a_index;
            beats_q  <= a_beats_m1;
            oob_q    <= oob_a;
        end
        if (host_d_valid && !host_d_ready && fresh_q) begin
            hold_q <= ram_rdata_i;
        end
    end

    // Next state and SRAM command.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        ram_req_o   = 1'b0;
        ram_we_o    = 1'b0;
        ram_addr_o  = base_q + RamAddrWidth'(idx_q);
        ram_wmask_o = '0;
        ram_wdata_o = host_a_data;

        case (state_q)
            StIdle: begin
                if (a_fire) begin
                    cnt_d      = a_beats_m1;
                    idx_d      = BeatCntW'(1);
                    ram_addr_o = a_index;
                    case (host_a_opcode)
                        OpGet: begin
                            ram_req_o = !oob_a;
                            state_d   = StRead;
                        end
                        OpPutFull, OpPutPartial: begin
                            ram_req_o   = !oob_a;
                            ram_we_o    = !oob_a;
                            ram_wmask_o = host_a_mask;
                            state_d     = (a_beats_m1 == '0) ? StWack : StWrite;
                        end
                        OpIntent: state_d = StWack;
                        default:  state_d = (a_beats_m1 == '0) ? StAresp : StAtom;
                    endcase
                end
            end
            StRead: begin
                if (d_fire) begin
                    if (cnt_q == '0) begin
                        state_d = StIdle;
                    end else begin
                        ram_req_o = !oob_q;
                        cnt_d     = cnt_q - BeatCntW'(1);
                        idx_d     = idx_q + BeatCntW'(1);
                    end
                end
            end
            StWrite: begin
                if (a_fire) begin
                    ram_req_o   = !oob_q;
                    ram_we_o    = !oob_q;
                    ram_wmask_o = host_a_mask;
                    cnt_d       = cnt_q - BeatCntW'(1);
                    idx_d       = idx_q + BeatCntW'(1);
                    if (cnt_q == BeatCntW'(1)) state_d = StWack;
                end
            end
            StAtom: begin
                if (a_fire) begin
                    cnt_d = cnt_q - BeatCntW'(1);
                    if (cnt_q == BeatCntW'(1)) begin
                        state_d = StAresp;
                        cnt_d   = beats_q;
                    end
                end
            end
            StAresp: begin
                if (d_fire) begin
                    if (cnt_q == '0) state_d = StIdle;
                    else             cnt_d   = cnt_q - BeatCntW'(1);
                end
            end
            StWack: begin
                if (d_fire) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // No SRAM access may leak out of a cycle in which reset is asserted.
        if (!rst_ni) begin
            ram_req_o = 1'b0;
            ram_we_o  = 1'b0;
        end

        a_ready_d = (state_d == StIdle) || (state_d == StWrite) || (state_d == StAtom);
        d_valid_d = (state_d == StRead) || (state_d == StWack) || (state_d == StAresp);
    end

    assign host_a_ready   = a_ready_q;
    assign host_d_valid   = d_valid_q;
    assign host_d_opcode  = (state_q == StWack) ? ((op_q == OpIntent) ? DHintAck : DAccessAck)
                                                : DAccessAckData;
    assign host_d_param   = '0;
    assign host_d_size    = size_q;
    assign host_d_source  = source_q;
    assign host_d_sink    = '0;
    assign host_d_denied  = oob_q || (state_q == StAresp);
    assign host_d_corrupt = (state_q == StAresp) || (oob_q && (state_q == StRead));
    assign host_d_data    = (oob_q || (state_q == StAresp)) ? '0
                          : (fresh_q ? ram_rdata_i : hold_q);

    assign host_b_valid   = 1'b0;
    assign host_b_opcode  = '0;
    assign host_b_param   = '0;
    assign host_b_size    = '0;
    assign host_b_source  = '0;
    assign host_b_address = '0;
    assign host_b_mask    = '0;
    assign host_b_data    = '0;
    assign host_b_corrupt = 1'b0;
    assign host_c_ready   = 1'b1;
    assign host_e_ready   = 1'b1;

    logic unused_inputs;
    assign unused_inputs = ^{host_a_param, host_a_corrupt, host_a_address, host_b_ready,
                             host_c_valid, host_c_opcode, host_c_param, host_c_size,
                             host_c_source, host_c_address, host_c_data, host_c_corrupt,
                             host_e_valid, host_e_sink};

endmodule

// File: tb/tb_tl_ram_terminal.sv
// Directed bench for tl_ram_terminal: SRAM model plus D-channel and SRAM-access scoreboards.
module tb_tl_ram_terminal;

    localparam logic [2:0] OP_PUTF = 3'd0, OP_PUTP = 3'd1, OP_ARITH = 3'd2,
                           OP_GET = 3'd4, OP_INTENT = 3'd5;
    localparam logic [2:0] D_ACK = 3'd0, D_ACKDATA = 3'd1, D_HINT = 3'd2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_ni;
    logic        a_valid, a_ready, a_corrupt;
    logic [2:0]  a_opcode, a_param, a_size;
    logic [1:0]  a_source;
    logic [55:0] a_address;
    logic [7:0]  a_mask;
    logic [63:0] a_data;
    logic        b_valid, b_corrupt;
    logic [2:0]  b_opcode, b_size;
    logic [1:0]  b_param, b_source;
    logic [55:0] b_address;
    logic [7:0]  b_mask;
    logic [63:0] b_data;
    logic        c_ready, e_ready;
    logic        d_valid, d_ready, d_denied, d_corrupt;
    logic [2:0]  d_opcode, d_size;
    logic [1:0]  d_param, d_source;
    logic [0:0]  d_sink;
    logic [63:0] d_data;
    logic        ram_req, ram_we;
    logic [9:0]  ram_addr;
    logic [7:0]  ram_wmask;
    logic [63:0] ram_wdata, ram_rdata;

    tl_ram_terminal dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .host_a_valid(a_valid), .host_a_ready(a_ready), .host_a_opcode(a_opcode),
        .host_a_param(a_param), .host_a_size(a_size), .host_a_source(a_source),
        .host_a_address(a_address), .host_a_mask(a_mask), .host_a_data(a_data),
        .host_a_corrupt(a_corrupt),
        .host_b_valid(b_valid), .host_b_ready(1'b0), .host_b_opcode(b_opcode),
        .host_b_param(b_param), .host_b_size(b_size), .host_b_source(b_source),
        .host_b_address(b_address), .host_b_mask(b_mask), .host_b_data(b_data),
        .host_b_corrupt(b_corrupt),
        .host_c_valid(1'b0), .host_c_ready(c_ready), .host_c_opcode(3'd0),
        .host_c_param(3'd0), .host_c_size(3'd0), .host_c_source(2'd0),
        .host_c_address(56'd0), .host_c_data(64'd0), .host_c_corrupt(1'b0),
        .host_d_valid(d_valid), .host_d_ready(d_ready), .host_d_opcode(d_opcode),
        .host_d_param(d_param), .host_d_size(d_size), .host_d_source(d_source),
        .host_d_sink(d_sink), .host_d_denied(d_denied), .host_d_data(d_data),
        .host_d_corrupt(d_corrupt),
        .host_e_valid(1'b0), .host_e_ready(e_ready), .host_e_sink(1'b0),
        .ram_req_o(ram_req), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
        .ram_wmask_o(ram_wmask), .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
    );

    // SRAM model: read data is valid only in the cycle after the read request.
    logic [63:0] mem [0:1023];
    always @(posedge clk) begin
        if (ram_req && ram_we)
            for (int b = 0; b < 8; b++)
                if (ram_wmask[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        if (ram_req && !ram_we) ram_rdata <= mem[ram_addr];
        else                    ram_rdata <= {$urandom, $urandom};
    end

    typedef struct packed {
        logic [2:0] op; logic [2:0] size; logic [1:0] src;
        logic den; logic cor; logic chk; logic [63:0] data;
    } d_exp_t;
    typedef struct packed {
        logic we; logic [9:0] addr; logic [7:0] mask; logic [63:0] data;
    } r_exp_t;

    d_exp_t      dq[$];
    r_exp_t      rq[$];
    logic [63:0] ref_mem [0:1023];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // D-channel scoreboard plus stall stability.
    logic        stalled = 1'b0;
    logic [63:0] held_data;
    always @(negedge clk) begin
        d_exp_t e;
        if (!rst_ni) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("d_stall_valid", d_valid, 1'b1);
                check("d_stall_data", d_data, held_data);
            end
            if (d_valid && d_ready) begin
                check("d_expected", dq.size() != 0, 1'b1);
                if (dq.size() != 0) begin
                    e = dq.pop_front();
                    check("d_opcode", d_opcode, e.op);
                    check("d_size", d_size, e.size);
                    check("d_source", d_source, e.src);
                    check("d_denied", d_denied, e.den);
                    check("d_corrupt", d_corrupt, e.cor);
                    check("d_param_sink", {d_param, d_sink}, 3'd0);
                    if (e.chk) check("d_data", d_data, e.data);
                end
            end
            stalled = d_valid && !d_ready;
            if (stalled) begin
                held_data = d_data;
                check("stall_no_ram_req", ram_req, 1'b0);
            end
        end
    end

    // SRAM access scoreboard: every access must have been predicted.
    always @(negedge clk) begin
        r_exp_t r;
        if (ram_req) begin
            check("ram_expected", rq.size() != 0, 1'b1);
            if (rq.size() != 0) begin
                r = rq.pop_front();
                check("ram_we", ram_we, r.we);
                check("ram_addr", ram_addr, r.addr);
                if (r.we) begin
                    check("ram_wmask", ram_wmask, r.mask);
                    check("ram_wdata", ram_wdata, r.data);
                end
            end
        end
    end

    task automatic send_a(input logic [2:0] op, input logic [2:0] sz, input logic [1:0] src,
                          input logic [55:0] addr, input logic [7:0] mask, input logic [63:0] data);
        int n = 0;
        a_valid = 1'b1; a_opcode = op; a_size = sz; a_source = src;
        a_address = addr; a_mask = mask; a_data = data;
        @(negedge clk);
        while (!a_ready && n < 50) begin n++; @(negedge clk); end
        check("a_accept", a_ready, 1'b1);
        @(posedge clk); #1;
        a_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        @(posedge clk); #1;
        while ((dq.size() != 0 || rq.size() != 0 || d_valid) && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("drain_d", dq.size(), 0);
        check("drain_ram", rq.size(), 0);
    endtask

    task automatic ref_write(input logic [9:0] idx, input logic [7:0] mask, input logic [63:0] data);
        for (int b = 0; b < 8; b++)
            if (mask[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] v;
        logic [3:0]  pat;
        rst_ni = 1'b0; a_valid = 1'b0; a_opcode = '0; a_param = '0; a_size = '0;
        a_source = '0; a_address = '0; a_mask = '0; a_data = '0; a_corrupt = 1'b0;
        d_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_ni = 1'b1;

        // Reset state and tie-offs
        @(negedge clk);
        check("rst_d_valid", d_valid, 1'b0);
        check("rst_ram_req", ram_req, 1'b0);
        check("rst_ram_we", ram_we, 1'b0);
        check("rst_a_ready", a_ready, 1'b1);
        check("tie_b_valid", b_valid, 1'b0);
        check("tie_c_e_ready", {c_ready, e_ready}, 2'b11);
        @(posedge clk); #1;

        // Single PutFullData then Get
        v = 64'hDEADBEEF_01234567;
        rq.push_back('{1'b1, 10'h8, 8'hFF, v});
        dq.push_back('{D_ACK, 3'd3, 2'd1, 1'b0, 1'b0, 1'b0, 64'd0});
        ref_write(10'h8, 8'hFF, v);
        send_a(OP_PUTF, 3'd3, 2'd1, 56'h40, 8'hFF, v);
        @(negedge clk); check("put_ack_latency", d_valid, 1'b1);
        drain();
        rq.push_back('{1'b0, 10'h8, 8'h00, 64'd0});
        dq.push_back('{D_ACKDATA, 3'd3, 2'd2, 1'b0, 1'b0, 1'b1, 64'hDEADBEEF_01234567});
        send_a(OP_GET, 3'd3, 2'd2, 56'h40, 8'hFF, 64'd0);
        @(negedge clk); check("get_latency", d_valid, 1'b1);
        drain();

        // PutPartialData on the low half
        rq.push_back('{1'b1, 10'h8, 8'h0F, 64'd0});
        dq.push_back('{D_ACK, 3'd3, 2'd1, 1'b0, 1'b0, 1'b0, 64'd0});
        ref_write(10'h8, 8'h0F, 64'd0);
        send_a(OP_PUTP, 3'd3, 2'd1, 56'h40, 8'h0F, 64'd0);
        drain();
        rq.push_back('{1'b0, 10'h8, 8'h00, 64'd0});
        dq.push_back('{D_ACKDATA, 3'd3, 2'd0, 1'b0, 1'b0, 1'b1, 64'hDEADBEEF_00000000});
        send_a(OP_GET, 3'd3, 2'd0, 56'h40, 8'hFF, 64'd0);
        drain();

        // 8-beat PutFullData with A-valid gaps
        for (int k = 0; k < 8; k++) begin
            v = {32'hC0DE0000 + 32'(k), 32'h00001000 + 32'(k)};
            rq.push_back('{1'b1, 10'(32 + k), 8'hFF, v});
            ref_write(10'(32 + k), 8'hFF, v);
            if (k == 7) dq.push_back('{D_ACK, 3'd6, 2'd3, 1'b0, 1'b0, 1'b0, 64'd0});
            send_a(OP_PUTF, 3'd6, 2'd3, 56'h100, 8'hFF, v);
            if (k < 7) begin
                @(negedge clk); check("burst_no_early_ack", d_valid, 1'b0);
                @(posedge clk); #1;
            end
        end
        @(negedge clk); check("burst_ack_latency", d_valid, 1'b1);
        drain();

        // 8-beat Get with D backpressure 1,0,0,1
        for (int k = 0; k < 8; k++) begin
            rq.push_back('{1'b0, 10'(32 + k), 8'h00, 64'd0});
            dq.push_back('{D_ACKDATA, 3'd6, 2'd0, 1'b0, 1'b0, 1'b1, ref_mem[32 + k]});
        end
        send_a(OP_GET, 3'd6, 2'd0, 56'h100, 8'hFF, 64'd0);
        pat = 4'b1001;
        for (int c = 0; c < 80 && dq.size() != 0; c++) begin
            d_ready = pat[c % 4];
            @(posedge clk); #1;
        end
        d_ready = 1'b1;
        drain();

        // Arithmetic: two beats consumed, two denied/corrupt data responses, no SRAM access
        for (int k = 0; k < 2; k++)
            dq.push_back('{D_ACKDATA, 3'd4, 2'd1, 1'b1, 1'b1, 1'b0, 64'd0});
        send_a(OP_ARITH, 3'd4, 2'd1, 56'h40, 8'hFF, 64'h1);
        @(negedge clk); check("atom_no_early_d", d_valid, 1'b0);
        @(posedge clk); #1;
        send_a(OP_ARITH, 3'd4, 2'd1, 56'h40, 8'hFF, 64'h2);
        drain();

        // Intent gives HintAck without SRAM access
        dq.push_back('{D_HINT, 3'd3, 2'd2, 1'b0, 1'b0, 1'b0, 64'd0});
        send_a(OP_INTENT, 3'd3, 2'd2, 56'h40, 8'hFF, 64'd0);
        drain();

        // Address just above the RAM range
`ifdef TL_RAM_TERMINAL_BOUNDS_EN
        dq.push_back('{D_ACKDATA, 3'd3, 2'd1, 1'b1, 1'b1, 1'b1, 64'd0});
`else
        rq.push_back('{1'b0, 10'h8, 8'h00, 64'd0});
        dq.push_back('{D_ACKDATA, 3'd3, 2'd1, 1'b0, 1'b0, 1'b1, ref_mem[8]});
`endif
        send_a(OP_GET, 3'd3, 2'd1, 56'h2040, 8'hFF, 64'd0);
        drain();

        // Reset while beat 3 of an 8-beat Get is on D
        for (int k = 0; k < 4; k++) rq.push_back('{1'b0, 10'(32 + k), 8'h00, 64'd0});
        for (int k = 0; k < 3; k++)
            dq.push_back('{D_ACKDATA, 3'd6, 2'd2, 1'b0, 1'b0, 1'b1, ref_mem[32 + k]});
        send_a(OP_GET, 3'd6, 2'd2, 56'h100, 8'hFF, 64'd0);
        repeat (3) begin @(posedge clk); #1; end
        rst_ni = 1'b0;
        @(negedge clk); check("beat3_valid", d_valid, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_mid_d_valid", d_valid, 1'b0);
        check("rst_mid_ram_req", ram_req, 1'b0);
        @(posedge clk); #1;
        rst_ni = 1'b1;
        @(negedge clk); check("rst_mid_a_ready", a_ready, 1'b1);
        @(posedge clk); #1;
        rq.push_back('{1'b0, 10'h8, 8'h00, 64'd0});
        dq.push_back('{D_ACKDATA, 3'd3, 2'd3, 1'b0, 1'b0, 1'b1, ref_mem[8]});
        send_a(OP_GET, 3'd3, 2'd3, 56'h40, 8'hFF, 64'd0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
